song_sequencer: RTL
===================

# song_sequencer

Beat-driven note sequencer sitting directly downstream of the BPM counter. It consumes the one-cycle beat pulse and walks a song ROM: fetch an entry, hold its note for the entry's duration in beats, then advance. The current note code goes to the tone generator / buzzer stage. Start, stop, pause and loop are handled here, and end-of-song is reported with a one-cycle flag.

## Interface
- ADDR_W, 8, song ROM address width
- NOTE_W, 6, note code width; code 0 = rest, all-ones = end-of-song marker
- DUR_W, 4, duration field width in beats; a value of 0 is treated as 1
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low (one clock; reset is synchronous and active-low)
- beat_tick  in  1  one-cycle beat pulse from the BPM counter
- start  in  1  level; a rising edge starts playback from address 0
- stop  in  1  level; returns the block to IDLE
- pause  in  1  level; while high, playback is frozen
- loop  in  1  sampled at end-of-song; 1 restarts from address 0
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  NOTE_W+DUR_W  {note[NOTE_W-1:0], dur[DUR_W-1:0]}; valid 1 cycle after rom_addr
- note  out  NOTE_W  current note code; 0 when not sounding
- note_on  out  1  high while a non-rest note is sounding
- playing  out  1  high in every state except IDLE
- song_done  out  1  one-cycle pulse at end of song

## Operation
- States: IDLE, FETCH, LOAD, PLAY, PAUSED, DONE.
- IDLE: note=0, note_on=0, rom_addr=0. A start rising edge (start high, registered start_d low) moves the block to FETCH.
- FETCH: drive rom_addr for one cycle, then go to LOAD. This covers the 1-cycle ROM latency.
- LOAD: decode rom_data.
  - If note is the end marker, go to DONE.
  - Otherwise latch note, set remaining = (dur==0 ? 1 : dur), and go to PLAY.
  - note_on = (note != 0) from the PLAY cycle onward.
- PLAY: on each effective tick, decrement remaining.
  - When a tick arrives with remaining==1: rom_addr+1, then FETCH. note/note_on hold until the next LOAD.
  - If rom_addr is all-ones when advancing, go to DONE instead. There is no address wrap.
- Effective tick: beat_tick in PLAY, or a pending_tick flag.
  - pending_tick is set by a beat_tick arriving in FETCH or LOAD.
  - It is consumed on the first PLAY cycle and cleared in every other state.
  - A beat_tick coinciding with a consumed pending_tick counts once.
- PAUSED: entered from PLAY when pause=1.
  - note_on=0 while paused; note and remaining are held.
  - beat_tick is ignored.
  - pause=0 returns the block to PLAY.
- DONE: song_done=1 for exactly this cycle.
  - If loop=1: rom_addr=0, then FETCH.
  - Else go to IDLE.
- stop=1 in any non-IDLE state forces IDLE on the next edge. It has priority over start, pause, tick and end-of-song. A song_done pulse is not produced.
- start edges are ignored outside IDLE.

## Timing
- Reset (rst=0 at clk edge): state=IDLE, rom_addr=0, note=0, note_on=0, playing=0, song_done=0, pending_tick=0, start_d=0. All outputs are registered.
- Start edge in cycle N:
  - FETCH in N+1.
  - LOAD in N+2.
  - PLAY, with note and note_on valid, in N+3.
- Note change latency from the final tick: 3 cycles (FETCH, LOAD, PLAY).
- A note lasts exactly dur effective ticks. A duration of 1 or more beats is guaranteed as long as ticks are ≥3 cycles apart.
- End marker read in LOAD at cycle M: song_done=1 in M+1. With loop=1, the entry at address 0 plays from M+4.
- Reset mid-song: the block returns to IDLE at the next edge regardless of state.

## Test plan
- Reset then start; ROM = {A:dur2},{B:dur1},{END}; tick every 10 cycles -> A held for 2 ticks, then B for 1, then song_done for one cycle; note=0 and playing=0 after.
- Entry {note 5, dur 0} -> treated as 1 beat; note=5 for exactly one tick.
- Rest entry {note 0, dur 3} -> note_on=0 and playing=1 for 3 ticks.
- pause held for 4 ticks during a 3-beat note -> note_on=0 and remaining unchanged; after release, the note ends 2 ticks later if 1 tick had elapsed before pause.
- loop=1 at END -> song_done pulse, then rom_addr=0 and the first note replays; stop asserted on the same cycle as a tick -> IDLE, with no advance and no song_done.
- beat_tick arriving in the FETCH cycle -> pending tick applied: remaining decrements on the first PLAY cycle. rst=0 mid-PLAY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/song_sequencer.sv
// Beat-driven song sequencer: walks a {note, dur} ROM one entry per note,
// holding each note for dur beats, with start/stop/pause/loop control.
module song_sequencer #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_tick,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_on,
    output logic                    playing,
    output logic                    song_done
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED, DONE} state_t;

    state_t            state;
    logic              start_d;
    logic              pending_tick;
    logic [DUR_W-1:0]  remaining;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              eff_tick;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    // A tick that landed during FETCH/LOAD is replayed on the first PLAY cycle.
    assign eff_tick = beat_tick | pending_tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            start_d      <= 1'b0;
            pending_tick <= 1'b0;
            remaining    <= '0;
            rom_addr     <= '0;
            note         <= '0;
            note_on      <= 1'b0;
            playing      <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            start_d   <= start;
            song_done <= 1'b0;
            if (stop && state != IDLE) begin
                state        <= IDLE;
                pending_tick <= 1'b0;
                rom_addr     <= '0;
                note         <= '0;
                note_on      <= 1'b0;
                playing      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        pending_tick <= 1'b0;
                        rom_addr     <= '0;
                        note         <= '0;
                        note_on      <= 1'b0;
                        if (start && !start_d) begin
                            state   <= FETCH;
                            playing <= 1'b1;
                        end
                    end
                    FETCH: begin
                        pending_tick <= pending_tick | beat_tick;
                        state        <= LOAD;
                    end
                    LOAD: begin
                        pending_tick <= pending_tick | beat_tick;
                        if (rom_note == '1) begin
                            state     <= DONE;
                            song_done <= 1'b1;
                            note      <= '0;
                            note_on   <= 1'b0;
                        end else begin
                            state     <= PLAY;
                            note      <= rom_note;
                            note_on   <= (rom_note != '0);
                            remaining <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                        end
                    end
                    PLAY: begin
                        pending_tick <= 1'b0;
                        if (pause) begin
                            state   <= PAUSED;
                            note_on <= 1'b0;
                        end else if (eff_tick) begin
                            if (remaining == DUR_W'(1)) begin
                                // Last address has no successor: treat as end of song.
                                if (rom_addr == '1) begin
                                    state     <= DONE;
                                    song_done <= 1'b1;
                                    note      <= '0;
                                    note_on   <= 1'b0;
                                end else begin
                                    state    <= FETCH;
                                    rom_addr <= rom_addr + 1'b1;
                                end
                            end else begin
                                remaining <= remaining - 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        pending_tick <= 1'b0;
                        if (!pause) begin
                            state   <= PLAY;
                            note_on <= (note != '0);
                        end
                    end
                    DONE: begin
                        pending_tick <= 1'b0;
                        rom_addr     <= '0;
                        if (loop) begin
                            state <= FETCH;
                        end else begin
                            state   <= IDLE;
                            playing <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
